// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbitration of NUM_REQ byte producers onto one
// 8N1 UART transmit line. The winning byte is latched and acked in the same
// IDLE edge that drives the start bit, so the line never waits on handshakes.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int BAUD    = 115200,
   parameter int F       = 50000000,
   localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] data,
   output logic [NUM_REQ-1:0]   ack,
   output logic [IDW-1:0]       grant_id,
   output logic                 busy,
   output logic                 tx
);

   localparam int DIV = F / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   typedef enum logic [1:0] {
      START = 2'b00,
      DATA  = 2'b01,
      STOP  = 2'b10,
      IDLE  = 2'b11
   } state_t;

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] ptr_nxt;
   logic           found;
   int             idx;
   logic [CW-1:0]  baud_cnt;
   logic [2:0]     bit_cnt;
   logic [7:0]     shreg;

   // Round-robin scan: first pending requester at or after ptr, wrapping.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
      ptr_nxt = (int'(winner) == NUM_REQ - 1) ? '0 : winner + IDW'(1);
   end

   // Frame FSM: grant/latch in IDLE, then start, 8 data bits LSB first, stop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         ack      <= '0;
         grant_id <= '0;
         ptr      <= '0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (found) begin
                  shreg       <= data[8*int'(winner) +: 8];
                  ack[winner] <= 1'b1;
                  grant_id    <= winner;
                  ptr         <= ptr_nxt;
                  state       <= START;
                  busy        <= 1'b1;
                  tx          <= 1'b0;
                  baud_cnt    <= '0;
               end
            end
            START: begin
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            DATA: begin
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shreg[bit_cnt + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            STOP: begin
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt <= '0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus a randomized producer phase.
// A spec-level model pushes {winner, byte} on every grant it predicts; a
// monitor pops on each ack and decodes the serial frame off tx.
module tb_uart_tx_arbiter;
   localparam int NR  = 4;
   localparam int DIV = 434;
   localparam int FR  = 10 * DIV;

   logic          clk  = 1'b0;
   logic          rst  = 1'b0;
   logic [NR-1:0] req  = '0;
   logic [8*NR-1:0] data = '0;
   logic [NR-1:0] ack;
   logic [1:0]    grant_id;
   logic          busy;
   logic          tx;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int acks_seen = 0;
   int m_grants = 0;
   int m_ptr = 0;
   int m_cnt = 0;

   typedef struct {
      int         id;
      logic [7:0] b;
   } exp_t;
   exp_t sb[$];

   uart_tx_arbiter #(.NUM_REQ(NR), .BAUD(115200), .F(50000000)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data),
      .ack(ack), .grant_id(grant_id), .busy(busy), .tx(tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Requester chosen by the round-robin rule: first pending index from p onward.
   function automatic int pick(input logic [NR-1:0] r, input int p);
      for (int k = 0; k < NR; k++)
         if (r[(p + k) % NR]) return (p + k) % NR;
      return 0;
   endfunction

   // Reference model: line is free once 10*DIV cycles have passed since a grant.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ptr <= 0;
         m_cnt <= 0;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
      end else if (req != 0) begin
         sb.push_back('{pick(req, m_ptr), data[8*pick(req, m_ptr) +: 8]});
         m_ptr    <= (pick(req, m_ptr) + 1) % NR;
         m_cnt    <= FR;
         m_grants <= m_grants + 1;
      end
   end

   task automatic mon_frame();
      exp_t e;
      logic [9:0] got;
      acks_seen++;
      check("ack_onehot", $countones(ack), 1);
      if (sb.size() == 0) begin
         check("unexpected_ack", ack, 0);
         return;
      end
      e = sb.pop_front();
      check("ack_id", ack, 64'(1) << e.id);
      check("grant_id", grant_id, e.id);
      check("busy_at_ack", busy, 1);
      got = '0;
      for (int i = 1; i <= FR; i++) begin
         @(negedge clk);
         if (!rst) return;
         if (ack != 0) check("ack_mid_frame", ack, 0);
         if (i % DIV == DIV / 2) got[i / DIV] = tx;
         if (i == FR - 1) check("busy_hold", busy, 1);
      end
      check("frame", got, {1'b1, e.b, 1'b0});
      check("busy_end", busy, 0);
      check("tx_idle", tx, 1);
   endtask

   // Monitor: every ack starts a frame that is decoded and compared.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && ack != 0) mon_frame();
      end
   end

   task automatic wait_ack(input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (ack != 0) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout: no ack within %0d cycles", max);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2 * FR; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: busy still %0b", busy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_prev;
      int bad;
      int target;
      int exp_ids[5] = '{0, 1, 2, 3, 0};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_ack", ack, 0);
      check("rst_grant", grant_id, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // single byte 0xD3 from requester 0
      data[7:0] = 8'hD3;
      req = 4'b0001;
      wait_ack(100);
      req = '0;
      wait_idle();

      // data change and req drop right after ack: frame keeps 0xD3, no 2nd ack
      data[7:0] = 8'hD3;
      req = 4'b0001;
      wait_ack(100);
      data[7:0] = 8'h2C;
      req = '0;
      wait_idle();
      repeat (300) @(negedge clk);
      check("no_second_ack", acks_seen, m_grants);

      // reset in the middle of DATA
      data[7:0] = 8'($urandom);
      req = 4'b0001;
      wait_ack(100);
      req = '0;
      repeat (4 * DIV) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_tx", tx, 1);
      check("abort_busy", busy, 0);
      check("abort_ack", ack, 0);
      check("abort_grant", grant_id, 0);
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || ack != 0) bad++;
      end
      check("idle_after_reset", bad, 0);

      // all four requesting: strict rotation, back-to-back frames
      do_reset();
      data = {8'h44, 8'h33, 8'h22, 8'h11};
      req = 4'b1111;
      t_prev = 0;
      for (int j = 0; j < 5; j++) begin
         wait_ack(2 * FR);
         check("rr_id", grant_id, exp_ids[j]);
         if (j > 0) check("rr_spacing", cyc - t_prev, FR + 1);
         t_prev = cyc;
      end
      req = '0;
      wait_idle();

      // move ptr to 2, then 1001 -> 3 then 0, then 0001 only -> 0
      req = 4'b0010;
      wait_ack(100);
      req = '0;
      wait_idle();
      data = {8'hA5, 8'h00, 8'h00, 8'h5A};
      req = 4'b1001;
      wait_ack(100);
      check("skip_first", grant_id, 3);
      wait_ack(2 * FR);
      check("skip_second", grant_id, 0);
      req = 4'b0001;
      wait_ack(2 * FR);
      check("single_again", grant_id, 0);
      req = '0;
      wait_idle();

      // request rising in the lone IDLE cycle is granted on the next edge
      data = $urandom;
      req = 4'b0001;
      wait_ack(100);
      req = '0;
      wait_idle();
      data = $urandom;
      req = 4'b0100;
      @(negedge clk);
      check("b2b_ack", ack, 4'b0100);
      check("b2b_grant", grant_id, 2);
      req = '0;

      // randomized producers: hold req until ack, data churns every cycle
      target = acks_seen + 2;
      for (int i = 0; i < 3 * FR; i++) begin
         @(negedge clk);
         if (acks_seen >= target) break;
         data = $urandom;
         for (int r = 0; r < NR; r++) begin
            if (ack[r]) req[r] = 1'($urandom_range(0, 1));
            else if (!req[r] && $urandom_range(0, 99) == 0) req[r] = 1'b1;
         end
      end
      req = '0;
      check("random_acks", acks_seen >= target, 1);
      wait_idle();
      repeat (5) @(negedge clk);

      check("total_acks", acks_seen, m_grants);
      check("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
